// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential repeated-subtraction divider.
package div_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle of the divider; master issues divisions, slave serves them.
interface seq_divider_if import div_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             complete;
  logic             div_by_zero;
  logic             busy;

  modport master (
    output start, a, b,
    input  quotient, remainder, complete, div_by_zero, busy
  );

  modport slave (
    input  start, a, b,
    output quotient, remainder, complete, div_by_zero, busy
  );

endinterface

// File: rtl/div_datapath.sv
// Operand/result registers with comparator, subtractor and quotient incrementer.
module div_datapath import div_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             sub,
  input  logic             set_dbz,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ge,
  output logic             zero,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             dbz
);

  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] quot_r;
  logic             dbz_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r  <= '0;
      div_r  <= '0;
      quot_r <= '0;
      dbz_r  <= 1'b0;
    end else if (ld) begin
      rem_r  <= a;
      div_r  <= b;
      quot_r <= '0;
      dbz_r  <= 1'b0;
    end else if (set_dbz) begin
      // remainder keeps the dividend so software can still see it
      quot_r <= '1;
      dbz_r  <= 1'b1;
    end else if (sub) begin
      rem_r  <= rem_r - div_r;
      quot_r <= quot_r + WIDTH'(1);
    end
  end

  assign ge   = (rem_r >= div_r);
  assign zero = (div_r == '0);
  assign quot = quot_r;
  assign rem  = rem_r;
  assign dbz  = dbz_r;

endmodule

// File: rtl/seq_divider.sv
// Unsigned divider: controller FSM sequencing one subtraction per clock in div_datapath.
//   state | meaning
//   IDLE  | waiting for start; results held
//   CHECK | subtract while remainder >= divisor, or flag divide-by-zero
//   DONE  | result final; complete pulses in the following cycle
module seq_divider import div_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  seq_divider_if.slave bus
);

  state_t           state;
  logic             complete_r;
  logic             busy_r;
  logic             ld;
  logic             sub;
  logic             set_dbz;
  logic             ge;
  logic             zero;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             dbz;

  always_comb begin
    ld      = 1'b0;
    sub     = 1'b0;
    set_dbz = 1'b0;
    case (state)
      IDLE:    ld = bus.start;
      CHECK: begin
        if (zero)    set_dbz = 1'b1;
        else if (ge) sub     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      complete_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      complete_r <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= CHECK;
            busy_r <= 1'b1;
          end
        end
        CHECK: begin
          if (zero || !ge) state <= DONE;
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  div_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk     (clk),
    .rst     (rst),
    .ld      (ld),
    .sub     (sub),
    .set_dbz (set_dbz),
    .a       (bus.a),
    .b       (bus.b),
    .ge      (ge),
    .zero    (zero),
    .quot    (quot),
    .rem     (rem),
    .dbz     (dbz)
  );

  assign bus.quotient    = quot;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;
  assign bus.complete    = complete_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: arithmetic reference model checked every cycle plus directed literal checks.
module tb_seq_divider;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: what the outputs must be, from division arithmetic and cycle counts.
  bit             m_valid = 0;
  bit             m_inflight = 0;
  int             m_done = 0;
  logic [W-1:0]   m_q = '0;
  logic [W-1:0]   m_r = '0;
  logic           m_dbz = 1'b0;

  always @(negedge clk) begin
    bit bexp;
    bit cexp;
    int q;
    if (m_valid) begin
      bexp = m_inflight && (cyc < m_done);
      cexp = m_inflight && (cyc == m_done);
      chk("busy", 32'(bus.busy), 32'(bexp));
      chk("complete", 32'(bus.complete), 32'(cexp));
      if (!bexp) begin
        chk("quotient", 32'(bus.quotient), 32'(m_q));
        chk("remainder", 32'(bus.remainder), 32'(m_r));
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(m_dbz));
      end
    end
    if (rst) begin
      m_valid    = 1;
      m_inflight = 0;
      m_q        = '0;
      m_r        = '0;
      m_dbz      = 1'b0;
    end else if (m_valid && !(m_inflight && cyc < m_done) && bus.start) begin
      if (bus.b == '0) begin
        q     = 0;
        m_q   = '1;
        m_r   = bus.a;
        m_dbz = 1'b1;
      end else begin
        q     = int'(bus.a) / int'(bus.b);
        m_q   = W'(q);
        m_r   = W'(int'(bus.a) % int'(bus.b));
        m_dbz = 1'b0;
      end
      m_inflight = 1;
      m_done     = cyc + 1 + q + 2;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_complete(input int acc, output int lat, output int low);
    low = 0;
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.complete) begin
        lat = cyc - acc;
        break;
      end
      if (!bus.busy) low++;
    end
    if (lat < 0) chk("complete_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz, input int elat);
    int acc, lat, low;
    step();
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    acc = cyc + 1;
    step();
    bus.start = 1'b0;
    wait_complete(acc, lat, low);
    chk("lit_latency", 32'(lat), 32'(elat));
    chk("lit_busy_gap", 32'(low), 32'd0);
    chk("lit_quotient", 32'(bus.quotient), 32'(eq));
    chk("lit_remainder", 32'(bus.remainder), 32'(er));
    chk("lit_dbz", 32'(bus.div_by_zero), 32'(edbz));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, lat, low, ncomp;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_quotient", 32'(bus.quotient), 32'd0);
    chk("rst_remainder", 32'(bus.remainder), 32'd0);
    chk("rst_complete", 32'(bus.complete), 32'd0);

    run_op(8'd13,  8'd4,   8'd3,   8'd1,  1'b0, 5);
    run_op(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 257);
    run_op(8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 2);
    run_op(8'd7,   8'd0,   8'hFF,  8'd7,  1'b1, 2);
    run_op(8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 2);
    run_op(8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 3);
    run_op(8'd254, 8'd16,  8'd15,  8'd14, 1'b0, 17);
    run_op(8'd1,   8'd0,   8'hFF,  8'd1,  1'b1, 2);

    // Abort a long division with reset; no completion may follow.
    step();
    bus.a     = 8'd200;
    bus.b     = 8'd3;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_quotient", 32'(bus.quotient), 32'd0);
    chk("abort_remainder", 32'(bus.remainder), 32'd0);
    chk("abort_dbz", 32'(bus.div_by_zero), 32'd0);
    ncomp = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.complete) ncomp++;
    end
    chk("abort_no_complete", 32'(ncomp), 32'd0);
    run_op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 5);

    // Start and operand changes while busy are ignored.
    step();
    bus.a     = 8'd20;
    bus.b     = 8'd6;
    bus.start = 1'b1;
    acc = cyc + 1;
    step();
    bus.start = 1'b0;
    step();
    bus.a     = 8'd100;
    bus.b     = 8'd10;
    bus.start = 1'b1;
    step();
    step();
    bus.start = 1'b0;
    wait_complete(acc, lat, low);
    chk("busy_ign_latency", 32'(lat), 32'd5);
    chk("busy_ign_quotient", 32'(bus.quotient), 32'd3);
    chk("busy_ign_remainder", 32'(bus.remainder), 32'd2);
    ncomp = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.complete || bus.busy) ncomp++;
    end
    chk("busy_ign_no_second", 32'(ncomp), 32'd0);

    // Start held high restarts immediately after each completion.
    step();
    bus.a     = 8'd10;
    bus.b     = 8'd3;
    bus.start = 1'b1;
    acc = cyc + 1;
    wait_complete(acc, lat, low);
    chk("held_latency", 32'(lat), 32'd5);
    chk("held_quotient", 32'(bus.quotient), 32'd3);
    chk("held_remainder", 32'(bus.remainder), 32'd1);
    acc = cyc + 1;
    @(negedge clk);
    chk("held_restart_busy", 32'(bus.busy), 32'd1);
    step();
    bus.start = 1'b0;
    wait_complete(acc, lat, low);
    chk("held2_latency", 32'(lat), 32'd5);
    chk("held2_quotient", 32'(bus.quotient), 32'd3);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: request a division; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH: dividend, sampled in the cycle start is accepted.
REQ-006 SHALL have port b, input, WIDTH: divisor, sampled in the cycle start is accepted.
REQ-007 SHALL have port quotient, output, WIDTH: registered result.
REQ-008 SHALL have port remainder, output, WIDTH: registered result.
REQ-009 SHALL have port complete, output, 1: one-cycle pulse marking results valid.
REQ-010 SHALL have port div_by_zero, output, 1: set with complete when the divisor is 0.
REQ-011 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-012 SHALL compute quotient and remainder by repeated subtraction, one subtraction per clock, unsigned.
REQ-013 SHALL implement states IDLE, CHECK and DONE, registered, with Moore-decoded outputs.
REQ-014 IDLE with start=1: latch rem_r<=a, div_r<=b, quot_r<=0 and div_by_zero<=0, then go to CHECK.
REQ-015 IDLE with start=0: hold all registers and outputs.
REQ-016 CHECK with div_r==0: set div_by_zero=1, quot_r=all-ones, keep rem_r equal to the dividend, go to DONE.
REQ-017 CHECK with rem_r>=div_r and div_r!=0: rem_r<=rem_r-div_r, quot_r<=quot_r+1, stay in CHECK.
REQ-018 CHECK with rem_r<div_r: go to DONE.
REQ-019 DONE: assert complete for exactly one cycle, then go to IDLE.
REQ-020 quotient and remainder SHALL equal quot_r and rem_r and stay stable from DONE until the next accepted start.
REQ-021 Latency: with start accepted at edge n, complete SHALL be high in the cycle after edge n+Q+2, where Q is the quotient (Q=0 for divide-by-zero).
REQ-022 Worst case (a=2^WIDTH-1, b=1) SHALL take 2^WIDTH+1 cycles.
REQ-023 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-024 a and b changing while busy=1 SHALL have no effect on the result.
REQ-025 quot_r increment SHALL never wrap, because Q <= 2^WIDTH-1 for b >= 1.
REQ-026 start held high continuously SHALL begin a new division in the IDLE cycle following DONE.

Reset
REQ-027 rst=1 at a rising edge SHALL force: state=IDLE, quotient=0, remainder=0, complete=0, div_by_zero=0, busy=0.
REQ-028 Reset SHALL take priority over start and over any in-progress division.
REQ-029 An aborted division SHALL produce no complete pulse.
REQ-030 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-031 A shared package div_pkg SHALL hold the state enum typedef (IDLE, CHECK, DONE) and the WIDTH default constant.
REQ-032 The datapath (rem_r, div_r, quot_r, comparator, subtractor, incrementer) SHALL sit in one sub-module, div_datapath.
REQ-033 seq_divider SHALL contain the controller and instantiate div_datapath.
REQ-034 The controller SHALL drive the datapath control signals ld, sub and set_dbz.
REQ-035 The datapath SHALL return the status flags ge and zero to the controller.

Verification
REQ-036 a=13, b=4, start pulse -> quotient=3, remainder=1, complete 5 cycles after the start edge, div_by_zero=0.
REQ-037 a=255, b=1 -> quotient=255, remainder=0, complete 257 cycles after start, busy high throughout.
REQ-038 a=5, b=9 -> quotient=0, remainder=5, complete 2 cycles after start.
REQ-039 a=7, b=0 -> div_by_zero=1, quotient=8'hFF, remainder=7, complete 2 cycles after start.
REQ-040 a=200, b=3, rst pulsed 10 cycles after start -> all outputs 0, no complete; then a=9, b=3 -> quotient=3, remainder=0.
REQ-041 Second start with a=100, b=10 while busy on a=20, b=6 -> first result quotient=3, remainder=2; second start ignored.
